imem_loader: RTL and testbench

- Writer side of the instruction memory. The CPU fetch path only reads that memory; this block fills it.
- Accepts a framed byte stream from a UART RX (or testbench) over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into the instruction memory write port and holds the CPU in reset while a load is in progress.
- Replaces the $readmemh-only flow with a runtime download path.

---
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader.sv | 181 ++++++++++++++++++
 tb/tb_imem_loader.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input handshake plus instruction-memory write
// port and load status, shared between the loader and its environment.
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  // Environment side: byte source, memory/CPU sink.
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err
  );

  // Loader side.
  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: runtime download path for the instruction memory.
// Frame: SYNC_BYTE, CNT_LO, CNT_HI, CNT little-endian words [, checksum].
// Optional macro IMEM_LOADER_CHECKSUM_EN adds an XOR checksum byte after the
// data and a CHECK state that verifies it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for SYNC_BYTE, other bytes dropped
// S_LEN0  | expecting word count low byte
// S_LEN1  | expecting word count high byte, range check
// S_DATA  | collecting bytes of the current word (lane 0..3)
// S_WRITE | one-cycle memory write strobe, input stalled
// S_CHECK | expecting checksum byte (checksum build only)
// S_DONE  | load finished, CPU released; behaves as idle
// S_ERR   | load aborted, CPU kept in reset until a new SYNC_BYTE
module imem_loader #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input logic          clk,
  input logic          reset_n,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_DONE, S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHECK
`endif
  } state_t;

  localparam logic [16:0] LP_DEPTH = 17'(DEPTH);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_index;
  logic [1:0]  r_lane;
  logic [23:0] r_bytes;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_cpu_hold;
  logic        r_load_done;
  logic        r_load_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  logic        w_rx_ready;
  logic        w_fire;
  logic        w_is_sync;
  logic [15:0] w_cnt_full;
  logic [15:0] w_index_next;

  // Input stalls only while the write strobe is out.
  always_comb begin
    w_rx_ready   = (r_state != S_WRITE);
    w_fire       = bus.rx_valid && w_rx_ready;
    w_is_sync    = (bus.rx_data == SYNC_BYTE);
    w_cnt_full   = {bus.rx_data, r_cnt[7:0]};
    w_index_next = r_index + 16'd1;
  end

  // Frame parser, word assembler and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_index     <= '0;
      r_lane      <= '0;
      r_bytes     <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= BASE_ADDR;
      r_mem_wdata <= '0;
      r_cpu_hold  <= 1'b0;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (w_fire && w_is_sync) begin
            r_state     <= S_LEN0;
            r_cpu_hold  <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum      <= '0;
`endif
          end
        end
        S_LEN0: begin
          if (w_fire) begin
            r_cnt[7:0] <= bus.rx_data;
            r_state    <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (w_fire) begin
            r_cnt <= w_cnt_full;
            if ({1'b0, w_cnt_full} > LP_DEPTH) begin
              r_state    <= S_ERR;
              r_load_err <= 1'b1;
            end else if (w_cnt_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_state     <= S_CHECK;
`else
              r_state     <= S_DONE;
              r_cpu_hold  <= 1'b0;
              r_load_done <= 1'b1;
`endif
            end else begin
              r_state <= S_DATA;
              r_index <= '0;
              r_lane  <= '0;
            end
          end
        end
        S_DATA: begin
          if (w_fire) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ bus.rx_data;
`endif
            r_lane <= r_lane + 2'd1;
            if (r_lane == 2'd3) begin
              r_mem_wdata <= {bus.rx_data, r_bytes};
              r_mem_addr  <= BASE_ADDR + {14'd0, r_index, 2'b00};
              r_mem_we    <= 1'b1;
              r_state     <= S_WRITE;
            end else begin
              r_bytes[r_lane*8 +: 8] <= bus.rx_data;
            end
          end
        end
        S_WRITE: begin
          r_mem_we <= 1'b0;
          r_index  <= w_index_next;
          r_lane   <= '0;
          if (w_index_next == r_cnt) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_state     <= S_CHECK;
`else
            r_state     <= S_DONE;
            r_cpu_hold  <= 1'b0;
            r_load_done <= 1'b1;
`endif
          end else begin
            r_state <= S_DATA;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (w_fire) begin
            if (bus.rx_data == r_csum) begin
              r_state     <= S_DONE;
              r_cpu_hold  <= 1'b0;
              r_load_done <= 1'b1;
            end else begin
              r_state    <= S_ERR;
              r_load_err <= 1'b1;
            end
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rx_ready  = w_rx_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.cpu_hold  = r_cpu_hold;
  assign bus.load_done = r_load_done;
  assign bus.load_err  = r_load_err;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader, default and checksum builds.
`timescale 1ns/1ps
module tb_imem_loader;
  logic clk = 1'b0;
  logic reset_n;
  imem_loader_if bus ();

  imem_loader #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_hs = 0;
  int rdy_bad = 0;
  int we_long = 0;
  logic prev_we = 1'b0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int wr_lat[$];
  int hs_cyc[$];
  logic [7:0] tx_q[$];

  // Passive monitor on the falling edge: logs writes, handshakes, ready rule.
  always @(negedge clk) begin
    cyc++;
    if (bus.mem_we) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
      wr_lat.push_back(cyc - last_hs);
    end
    if (bus.mem_we && prev_we) we_long++;
    if (reset_n && (bus.rx_ready !== !bus.mem_we)) rdy_bad++;
    prev_we = bus.mem_we;
    if (reset_n && bus.rx_valid && bus.rx_ready) begin
      last_hs = cyc;
      hs_cyc.push_back(cyc);
    end
  end

  task automatic clear_logs();
    wr_addr.delete(); wr_data.delete(); wr_lat.delete(); hs_cyc.delete();
    rdy_bad = 0; we_long = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    while (!bus.rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL send_byte_timeout: rx_ready stuck 0 for byte %h", b);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_q(input bit gap);
    foreach (tx_q[i]) begin
      send_byte(tx_q[i]);
      if (gap) idle(1);
    end
    bus.rx_valid = 1'b0;
    tx_q.delete();
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic add_csum();
    logic [7:0] x = 8'h00;
    for (int i = 3; i < tx_q.size(); i++) x ^= tx_q[i];
    tx_q.push_back(x);
  endtask
`endif

  task automatic wait_end(input string name);
    int n = 0;
    bus.rx_valid = 1'b0;
    while (!(bus.load_done || bus.load_err) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 30) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no load_done/load_err within 30 cycles", name);
    end
    idle(2);
  endtask

  task automatic test_reset();
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", bus.mem_wdata); end
    checks++; if (bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL rst_hold: got %b want 0", bus.cpu_hold); end
    checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", bus.load_done); end
    checks++; if (bus.load_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus.load_err); end
    checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bus.rx_ready); end
  endtask

  task automatic test_basic_load();
    clear_logs();
    send_byte(8'h11); idle(1);
    checks++; if (bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL basic_ignore_hold: got %b want 0", bus.cpu_hold); end
    send_byte(8'hA5);
    checks++; if (bus.cpu_hold !== 1'b1) begin errors++; $display("FAIL basic_hold_at_sync: got %b want 1", bus.cpu_hold); end
    tx_q = '{8'h02, 8'h00, 8'h13, 8'h07, 8'h10, 8'h00, 8'hB7, 8'h07, 8'h00, 8'h40};
`ifdef IMEM_LOADER_CHECKSUM_EN
    tx_q.push_front(8'h00); tx_q.push_front(8'h00); tx_q.push_front(8'h00);
    add_csum();
    void'(tx_q.pop_front()); void'(tx_q.pop_front()); void'(tx_q.pop_front());
`endif
    send_q(1'b1);
    wait_end("basic");
    checks++; if (wr_addr.size() !== 2) begin errors++; $display("FAIL basic_nwrites: got %0d want 2", wr_addr.size()); end
    if (wr_addr.size() == 2) begin
      checks++; if (wr_addr[0] !== 32'h0) begin errors++; $display("FAIL basic_addr0: got %h want 00000000", wr_addr[0]); end
      checks++; if (wr_data[0] !== 32'h00100713) begin errors++; $display("FAIL basic_data0: got %h want 00100713", wr_data[0]); end
      checks++; if (wr_addr[1] !== 32'h4) begin errors++; $display("FAIL basic_addr1: got %h want 00000004", wr_addr[1]); end
      checks++; if (wr_data[1] !== 32'h400007B7) begin errors++; $display("FAIL basic_data1: got %h want 400007b7", wr_data[1]); end
      checks++; if (wr_lat[0] !== 1 || wr_lat[1] !== 1) begin errors++; $display("FAIL basic_latency: got %0d,%0d want 1,1", wr_lat[0], wr_lat[1]); end
    end
    checks++; if (we_long !== 0) begin errors++; $display("FAIL basic_we_width: got %0d long strobes want 0", we_long); end
    checks++; if (bus.load_done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", bus.load_done); end
    checks++; if (bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL basic_release: got %b want 0", bus.cpu_hold); end
    checks++; if (bus.load_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", bus.load_err); end
  endtask

  task automatic test_back_to_back();
    int exp_hs;
    clear_logs();
    tx_q = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
             8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h04};
`ifdef IMEM_LOADER_CHECKSUM_EN
    add_csum();
    exp_hs = 16;
`else
    exp_hs = 15;
`endif
    send_q(1'b0);
    wait_end("b2b");
    checks++; if (wr_addr.size() !== 3) begin errors++; $display("FAIL b2b_nwrites: got %0d want 3", wr_addr.size()); end
    if (wr_addr.size() == 3) begin
      checks++; if (wr_addr[0] !== 32'h0 || wr_addr[1] !== 32'h4 || wr_addr[2] !== 32'h8) begin
        errors++; $display("FAIL b2b_addr: got %h %h %h want 0 4 8", wr_addr[0], wr_addr[1], wr_addr[2]); end
      checks++; if (wr_data[0] !== 32'h44332211) begin errors++; $display("FAIL b2b_data0: got %h want 44332211", wr_data[0]); end
      checks++; if (wr_data[1] !== 32'hA5A5A5A5) begin errors++; $display("FAIL b2b_data1: got %h want a5a5a5a5", wr_data[1]); end
      checks++; if (wr_data[2] !== 32'h04030201) begin errors++; $display("FAIL b2b_data2: got %h want 04030201", wr_data[2]); end
    end
    checks++; if (hs_cyc.size() !== exp_hs) begin errors++; $display("FAIL b2b_handshakes: got %0d want %0d", hs_cyc.size(), exp_hs); end
    if (hs_cyc.size() >= 15) begin
      checks++; if (hs_cyc[14] - hs_cyc[3] !== 13) begin
        errors++; $display("FAIL b2b_throughput: got %0d cycles want 13", hs_cyc[14] - hs_cyc[3]); end
    end
    checks++; if (rdy_bad !== 0) begin errors++; $display("FAIL b2b_ready_rule: got %0d bad cycles want 0", rdy_bad); end
    checks++; if (bus.load_done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", bus.load_done); end
  endtask

  task automatic test_reset_mid_load();
    clear_logs();
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB};
    send_q(1'b0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL mid_rst_we: got %b want 0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL mid_rst_addr: got %h want 0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL mid_rst_wdata: got %h want 0", bus.mem_wdata); end
    checks++; if (bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL mid_rst_hold: got %b want 0", bus.cpu_hold); end
    checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL mid_rst_done: got %b want 0", bus.load_done); end
    reset_n = 1'b1;
    idle(2);
    checks++; if (wr_addr.size() !== 0) begin errors++; $display("FAIL mid_rst_nowrite: got %0d writes want 0", wr_addr.size()); end
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
`ifdef IMEM_LOADER_CHECKSUM_EN
    add_csum();
`endif
    send_q(1'b0);
    wait_end("mid_rst");
    checks++; if (wr_addr.size() !== 2) begin errors++; $display("FAIL mid_rst_nwrites: got %0d want 2", wr_addr.size()); end
    if (wr_addr.size() == 2) begin
      checks++; if (wr_data[0] !== 32'h40302010 || wr_addr[0] !== 32'h0) begin
        errors++; $display("FAIL mid_rst_word0: got %h@%h want 40302010@0", wr_data[0], wr_addr[0]); end
      checks++; if (wr_data[1] !== 32'h80706050 || wr_addr[1] !== 32'h4) begin
        errors++; $display("FAIL mid_rst_word1: got %h@%h want 80706050@4", wr_data[1], wr_addr[1]); end
    end
    checks++; if (bus.load_done !== 1'b1) begin errors++; $display("FAIL mid_rst_done_after: got %b want 1", bus.load_done); end
  endtask

  task automatic test_overflow();
    clear_logs();
    tx_q = '{8'hA5, 8'h01, 8'h04};
    send_q(1'b0);
    wait_end("ovf");
    checks++; if (bus.load_err !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b want 1", bus.load_err); end
    checks++; if (bus.cpu_hold !== 1'b1) begin errors++; $display("FAIL ovf_hold: got %b want 1", bus.cpu_hold); end
    checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL ovf_done: got %b want 0", bus.load_done); end
    checks++; if (wr_addr.size() !== 0) begin errors++; $display("FAIL ovf_nowrite: got %0d writes want 0", wr_addr.size()); end
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef IMEM_LOADER_CHECKSUM_EN
    add_csum();
`endif
    send_q(1'b0);
    wait_end("ovf_recover");
    checks++; if (bus.load_done !== 1'b1 || bus.load_err !== 1'b0) begin
      errors++; $display("FAIL ovf_recover: got done=%b err=%b want 1 0", bus.load_done, bus.load_err); end
    checks++; if (wr_data.size() !== 1 || bus.mem_wdata !== 32'hEFBEADDE) begin
      errors++; $display("FAIL ovf_recover_word: got %0d writes data %h want 1 efbeadde", wr_data.size(), bus.mem_wdata); end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clear_logs();
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF};
    send_q(1'b0);
    wait_end("csum_bad");
    checks++; if (wr_data.size() !== 1 || bus.mem_wdata !== 32'h44332211) begin
      errors++; $display("FAIL csum_bad_write: got %0d writes data %h want 1 44332211", wr_data.size(), bus.mem_wdata); end
    checks++; if (bus.load_err !== 1'b1 || bus.cpu_hold !== 1'b1) begin
      errors++; $display("FAIL csum_bad_err: got err=%b hold=%b want 1 1", bus.load_err, bus.cpu_hold); end
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_q(1'b0);
    wait_end("csum_good");
    checks++; if (bus.load_done !== 1'b1 || bus.cpu_hold !== 1'b0) begin
      errors++; $display("FAIL csum_good_done: got done=%b hold=%b want 1 0", bus.load_done, bus.cpu_hold); end
  endtask
`endif

  task automatic test_zero_count();
    clear_logs();
    tx_q = '{8'hA5, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    tx_q.push_back(8'h00);
`endif
    send_q(1'b0);
    wait_end("zero");
    checks++; if (wr_addr.size() !== 0) begin errors++; $display("FAIL zero_nowrite: got %0d writes want 0", wr_addr.size()); end
    checks++; if (bus.load_done !== 1'b1 || bus.load_err !== 1'b0) begin
      errors++; $display("FAIL zero_done: got done=%b err=%b want 1 0", bus.load_done, bus.load_err); end
    checks++; if (bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL zero_hold: got %b want 0", bus.cpu_hold); end
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset_n = 1'b1;
    idle(2);
    test_basic_load();
    test_back_to_back();
    test_reset_mid_load();
    test_overflow();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_zero_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
